// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-level delivery port of the UART receive frame controller.
// Valid/ready: the controller (master) raises VALID with DATA, FRAME_ERR and
// PARITY_ERR stable; the byte transfers on a rising edge where VALID && READY.
// While VALID is high and READY is low, the held contents never change.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 READY;
  logic                 FRAME_ERR;
  logic                 PARITY_ERR;

  modport master (
    output DATA,
    output VALID,
    output FRAME_ERR,
    output PARITY_ERR,
    input  READY
  );

  modport slave (
    input  DATA,
    input  VALID,
    input  FRAME_ERR,
    input  PARITY_ERR,
    output READY
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller on the 16x oversampling clock.
// Samples RXD at mid-bit, sequences start/data/parity/stop and hands each
// completed frame to a single-entry holding register (valid/ready port).
// A frame completing while the held byte is still unaccepted is dropped and
// flagged with a one-cycle OVERRUN pulse.
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK_x16,
  input  logic                 RST,
  input  logic                 RXD,
  uart_rx_frame_ctrl_if.master rx_if,
  output logic                 OVERRUN,
  output logic                 BUSY,
  output logic [2:0]           state_dbg_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  logic                 rxd_s;
  logic [2:0]           state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic                 frame_fe;
  logic                 frame_pe;

  assign rxd_s = sync2_q;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge CLK_x16) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
    end
  end

  // Frame sequencing and holding-register next-state logic.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = 1'b0;
    done    = 1'b0;

    // The tick only runs while a bit is being timed.
    if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
      tick_d = tick_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_d = ST_START;
          tick_d  = 4'd0;
        end
      end
      ST_START: begin
        if (tick_q == 4'd7 && rxd_s) begin
          state_d = ST_IDLE;   // glitch shorter than half a bit
        end else if (tick_q == 4'd15) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick_q == 4'd7) begin
          // Shift in at the MSB so the first bit lands at bit 0.
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
        end
        if (tick_q == 4'd15) begin
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick_q == 4'd7) begin
          par_d = rxd_s;
        end
        if (tick_q == 4'd15) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop-bit to leave margin for the next start bit.
        if (tick_q == 4'd7) begin
          done    = 1'b1;
          state_d = rxd_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        // A break or stuck-low line must go high before re-arming.
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    frame_fe = !rxd_s;
    frame_pe = (PARITY_EN != 0) &&
               ((^shift_q ^ par_q) != (PARITY_ODD != 0));

    if (done) begin
      if (!valid_q || rx_if.READY) begin
        data_d  = shift_q;
        fe_d    = frame_fe;
        pe_d    = frame_pe;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;         // held byte wins; new frame is lost
      end
    end else if (valid_q && rx_if.READY) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and holding register; reset aborts any frame in flight.
  always_ff @(posedge CLK_x16) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tick_q  <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.DATA       = data_q;
  assign rx_if.VALID      = valid_q;
  assign rx_if.FRAME_ERR  = fe_q;
  assign rx_if.PARITY_ERR = pe_q;
  assign OVERRUN          = ovr_q;
  assign BUSY             = (state_q != ST_IDLE);
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: one 8N1 instance and one 8E1 instance.
// Delivered bytes are checked by a scoreboard; edge-exact behaviour by
// hand-written sequences and a table of parity/framing vectors.
module tb_uart_rx_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   edge_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- DUTs ----------------
  logic       rxd_n, rxd_e;
  logic       ovr_n, ovr_e, busy_n, busy_e;
  logic [2:0] st_n, st_e;

  uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if_n ();
  uart_rx_frame_ctrl_if #(.DATA_BITS(8)) if_e ();

  uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .CLK_x16(clk), .RST(rst), .RXD(rxd_n), .rx_if(if_n),
    .OVERRUN(ovr_n), .BUSY(busy_n), .state_dbg_o(st_n)
  );

  uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
    .CLK_x16(clk), .RST(rst), .RXD(rxd_e), .rx_if(if_e),
    .OVERRUN(ovr_e), .BUSY(busy_e), .state_dbg_o(st_e)
  );

  // ---------------- checking ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entries are {FRAME_ERR, PARITY_ERR, DATA}.
  logic [9:0] exp_n[$];
  logic [9:0] exp_e[$];
  logic [9:0] e_n, e_e;

  // A byte is delivered on each edge with VALID && READY; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && if_n.VALID && if_n.READY) begin
      if (exp_n.size() == 0) begin
        chk("n_unexpected_frame", {22'd0, if_n.FRAME_ERR, if_n.PARITY_ERR, if_n.DATA}, 32'hffff_ffff);
      end else begin
        e_n = exp_n.pop_front();
        chk("n_frame", {22'd0, if_n.FRAME_ERR, if_n.PARITY_ERR, if_n.DATA}, {22'd0, e_n});
      end
    end
    if (!rst && if_e.VALID && if_e.READY) begin
      if (exp_e.size() == 0) begin
        chk("e_unexpected_frame", {22'd0, if_e.FRAME_ERR, if_e.PARITY_ERR, if_e.DATA}, 32'hffff_ffff);
      end else begin
        e_e = exp_e.pop_front();
        chk("e_frame", {22'd0, if_e.FRAME_ERR, if_e.PARITY_ERR, if_e.DATA}, {22'd0, e_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_abs(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_n(input logic [7:0] d, input logic stop_v, input int stop_len);
    rxd_n = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd_n = d[i];
      tick(16);
    end
    rxd_n = stop_v;
    tick(stop_len);
    rxd_n = 1'b1;
  endtask

  task automatic frame_e(input logic [7:0] d, input logic par, input logic stop_v);
    rxd_e = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd_e = d[i];
      tick(16);
    end
    rxd_e = par;
    tick(16);
    rxd_e = stop_v;
    tick(16);
    rxd_e = 1'b1;
  endtask

  // ---------------- 8E1 vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[6];
  int   base;

  initial begin
    vecs[0] = '{d: 8'h07, par: 1'b0, stop: 1'b1, exp_fe: 1'b0, exp_pe: 1'b1};
    vecs[1] = '{d: 8'h07, par: 1'b1, stop: 1'b1, exp_fe: 1'b0, exp_pe: 1'b0};
    vecs[2] = '{d: 8'h00, par: 1'b0, stop: 1'b1, exp_fe: 1'b0, exp_pe: 1'b0};
    vecs[3] = '{d: 8'hFF, par: 1'b1, stop: 1'b1, exp_fe: 1'b0, exp_pe: 1'b1};
    vecs[4] = '{d: 8'h81, par: 1'b0, stop: 1'b1, exp_fe: 1'b0, exp_pe: 1'b0};
    vecs[5] = '{d: 8'h5A, par: 1'b0, stop: 1'b0, exp_fe: 1'b1, exp_pe: 1'b0};

    checks     = 0;
    errors     = 0;
    edge_n     = 0;
    rst        = 1'b1;
    rxd_n      = 1'b1;
    rxd_e      = 1'b1;
    if_n.READY = 1'b1;
    if_e.READY = 1'b1;

    // Reset values on both instances.
    tick(3);
    chk("rst_data_n",  {24'd0, if_n.DATA}, 32'd0);
    chk("rst_valid_n", {31'd0, if_n.VALID}, 32'd0);
    chk("rst_fe_n",    {31'd0, if_n.FRAME_ERR}, 32'd0);
    chk("rst_pe_n",    {31'd0, if_n.PARITY_ERR}, 32'd0);
    chk("rst_ovr_n",   {31'd0, ovr_n}, 32'd0);
    chk("rst_busy_n",  {31'd0, busy_n}, 32'd0);
    chk("rst_valid_e", {31'd0, if_e.VALID}, 32'd0);
    chk("rst_busy_e",  {31'd0, busy_e}, 32'd0);
    chk("rst_state_e", {29'd0, st_e}, 32'd0);
    rst = 1'b0;
    tick(4);

    // 8N1 0xA5, READY high: edge-exact completion at 155.
    exp_n.push_back({1'b0, 1'b0, 8'hA5});
    base = edge_n;
    fork
      frame_n(8'hA5, 1'b1, 16);
      begin
        wait_abs(base + 154);
        chk("a5_valid_154", {31'd0, if_n.VALID}, 32'd0);
        chk("a5_busy_154",  {31'd0, busy_n}, 32'd1);
        wait_abs(base + 155);
        chk("a5_valid_155", {31'd0, if_n.VALID}, 32'd1);
        chk("a5_data_155",  {24'd0, if_n.DATA}, 32'hA5);
        chk("a5_fe_155",    {31'd0, if_n.FRAME_ERR}, 32'd0);
        chk("a5_busy_155",  {31'd0, busy_n}, 32'd0);
        wait_abs(base + 156);
        chk("a5_valid_156", {31'd0, if_n.VALID}, 32'd0);
      end
    join
    tick(8);

    // False start: line low for 5 cycles only.
    base  = edge_n;
    rxd_n = 1'b0;
    tick(5);
    rxd_n = 1'b1;
    wait_abs(base + 10);
    chk("fs_busy_10",  {31'd0, busy_n}, 32'd1);
    chk("fs_state_10", {29'd0, st_n}, 32'd1);
    wait_abs(base + 11);
    chk("fs_busy_11",  {31'd0, busy_n}, 32'd0);
    chk("fs_state_11", {29'd0, st_n}, 32'd0);
    tick(30);

    // 8N1 0x3C with stop bit held low for 40 cycles.
    exp_n.push_back({1'b1, 1'b0, 8'h3C});
    base = edge_n;
    fork
      frame_n(8'h3C, 1'b0, 40);
      begin
        wait_abs(base + 155);
        chk("fe_valid_155", {31'd0, if_n.VALID}, 32'd1);
        chk("fe_data_155",  {24'd0, if_n.DATA}, 32'h3C);
        chk("fe_flag_155",  {31'd0, if_n.FRAME_ERR}, 32'd1);
        wait_abs(base + 186);
        chk("fe_busy_186",  {31'd0, busy_n}, 32'd1);
        chk("fe_state_186", {29'd0, st_n}, 32'd5);
        wait_abs(base + 187);
        chk("fe_busy_187",  {31'd0, busy_n}, 32'd0);
      end
    join
    tick(40);

    // 8E1 vector table.
    for (int i = 0; i < 6; i++) begin
      exp_e.push_back({vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].d});
      base = edge_n;
      fork
        frame_e(vecs[i].d, vecs[i].par, vecs[i].stop);
        begin
          wait_abs(base + 170);
          chk("vec_valid_170", {31'd0, if_e.VALID}, 32'd0);
          wait_abs(base + 171);
          chk("vec_valid_171", {31'd0, if_e.VALID}, 32'd1);
          chk("vec_pe_171",    {31'd0, if_e.PARITY_ERR}, {31'd0, vecs[i].exp_pe});
          chk("vec_fe_171",    {31'd0, if_e.FRAME_ERR}, {31'd0, vecs[i].exp_fe});
        end
      join
      rxd_e = 1'b1;
      tick(24);
    end

    // Overrun: READY low, 0x11 then 0x22 back-to-back.
    if_n.READY = 1'b0;
    exp_n.push_back({1'b0, 1'b0, 8'h11});
    base = edge_n;
    fork
      begin
        frame_n(8'h11, 1'b1, 16);
        frame_n(8'h22, 1'b1, 16);
      end
      begin
        wait_abs(base + 155);
        chk("ov_first_ovr",   {31'd0, ovr_n}, 32'd0);
        chk("ov_first_valid", {31'd0, if_n.VALID}, 32'd1);
        wait_abs(base + 160 + 154);
        chk("ov_ovr_154",     {31'd0, ovr_n}, 32'd0);
        wait_abs(base + 160 + 155);
        chk("ov_ovr_155",     {31'd0, ovr_n}, 32'd1);
        chk("ov_data_155",    {24'd0, if_n.DATA}, 32'h11);
        chk("ov_valid_155",   {31'd0, if_n.VALID}, 32'd1);
        wait_abs(base + 160 + 156);
        chk("ov_ovr_156",     {31'd0, ovr_n}, 32'd0);
      end
    join
    tick(5);
    chk("ov_held_data", {24'd0, if_n.DATA}, 32'h11);
    if_n.READY = 1'b1;
    tick(1);
    chk("ov_valid_after_ready", {31'd0, if_n.VALID}, 32'd0);
    tick(10);

    // Reset at edge 60 of a frame, then a clean 0x5A.
    base = edge_n;
    fork
      frame_n(8'hFF, 1'b1, 16);
      begin
        wait_abs(base + 59);
        rst = 1'b1;
        tick(1);
        chk("mr_busy",  {31'd0, busy_n}, 32'd0);
        chk("mr_valid", {31'd0, if_n.VALID}, 32'd0);
        chk("mr_data",  {24'd0, if_n.DATA}, 32'd0);
        chk("mr_state", {29'd0, st_n}, 32'd0);
        chk("mr_ovr",   {31'd0, ovr_n}, 32'd0);
        rst = 1'b0;
        wait_abs(base + 156);
        chk("mr_no_frame", {31'd0, if_n.VALID}, 32'd0);
        chk("mr_no_ovr",   {31'd0, ovr_n}, 32'd0);
      end
    join
    tick(20);
    exp_n.push_back({1'b0, 1'b0, 8'h5A});
    base = edge_n;
    fork
      frame_n(8'h5A, 1'b1, 16);
      begin
        wait_abs(base + 155);
        chk("post_rst_valid", {31'd0, if_n.VALID}, 32'd1);
        chk("post_rst_data",  {24'd0, if_n.DATA}, 32'h5A);
      end
    join
    tick(20);

    chk("sb_n_drained", exp_n.size(), 32'd0);
    chk("sb_e_drained", exp_e.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
